alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command-queue entries (power of 2, >=2).
REQ-002 Parameter MUL_LAT, default 2, cycles the downstream multiplier path needs before its product is valid.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  command offered.
REQ-006 in_ready  out  1  command accepted when in_valid & in_ready at an edge.
REQ-007 in_opcode  in  4  compact operation code (map in REQ-012).
REQ-008 in_a, in_b  in  16 each  operands.
REQ-009 alu_a, alu_b  out  16 each; alu_op  out  25  operands and ASCII op string driven into the ALU.
REQ-010 alu_out  in  32  ALU result.
REQ-011 res_valid  out  1; res_ready  in  1; res_data  out  32; res_err  out  1  result handshake and illegal-op flag.

Function
REQ-012 Opcode map 0..14: "|" "&" "~|" "^" "~^" ">>" "<<" "asr" "asl" "ror" "rol" "cmp" "+" "-" "*"; alu_op is the string's ASCII bytes zero-extended to 25 bits (e.g. "+"=25'h00002B, "asr"=25'h617372).
REQ-013 Opcode 15 is illegal; no ALU operation is issued; it completes with res_data=0, res_err=1.
REQ-014 FSM states IDLE, EXEC, DONE; IDLE->EXEC on command available (opcode 15: IDLE->DONE directly); EXEC->DONE when cycle counter expires; DONE->IDLE on res_valid & res_ready.
REQ-015 On entering EXEC, alu_a, alu_b and alu_op are registered and held constant throughout EXEC.
REQ-016 EXEC lasts L cycles: L=1 for opcodes 0..13, L=MUL_LAT for opcode 14; alu_out is sampled into res_data at the last EXEC edge.
REQ-017 Outside EXEC, alu_a=0, alu_b=0, alu_op=0.
REQ-018 res_valid=1 exactly in DONE; res_data and res_err are stable while res_valid=1 and res_ready=0.
REQ-019 Commands complete in acceptance order; one command in flight; max throughput is one result per L+2 cycles.
REQ-020 res_err=0 for opcodes 0..14.

Reset
REQ-021 When rst=1 at an edge: state=IDLE, queue emptied, counter=0, res_valid=0, res_data=0, res_err=0, alu_a=alu_b=0, alu_op=0.
REQ-022 Reset during EXEC or DONE discards the in-flight command and its result without a handshake.
REQ-023 in_ready=0 during the cycle rst=1.

Configuration
REQ-024 Macro ALU_SEQ_FIFO_EN defined: commands enter a FIFO_DEPTH-entry queue; in_ready = queue not full; IDLE pops the head.
REQ-025 With ALU_SEQ_FIFO_EN: acceptance at edge N with empty queue and IDLE gives EXEC from edge N+1; res_valid rises after edge N+1+L.
REQ-026 With ALU_SEQ_FIFO_EN: push and pop at the same edge leave the count unchanged; a push when full is not possible because in_ready=0, even if a pop occurs at that edge.
REQ-027 Without ALU_SEQ_FIFO_EN: no queue; in_ready = (state==IDLE); acceptance at edge N enters EXEC at N; res_valid rises after edge N+L.

Structure
REQ-028 Shared package holds opcode localparams, the 16-entry opcode->ASCII table and the FSM state encoding.
REQ-029 Sub-module alu_seq_fifo (parameterised width/depth, full/empty/count) is instantiated only under ALU_SEQ_FIFO_EN.

Verification
REQ-030 Opcode 12, a=16'hFFFF, b=16'h0001, alu_out model = a+b with carry in bit 16 -> alu_op=25'h00002B during EXEC; res_data=32'h00010000, res_err=0.
REQ-031 Opcode 14, a=16'h0100, b=16'h0100, MUL_LAT=2 -> alu_op=25'h00002A held 2 cycles; res_data=32'h00010000 exactly L cycles after EXEC entry.
REQ-032 res_ready held low 5 cycles after res_valid -> res_data and res_err stable; no second result; in_ready low (no FIFO) or queue fills to 4 and in_ready drops (FIFO).
REQ-033 Opcode 15 -> no EXEC cycle; alu_op stays 0; res_data=0, res_err=1.
REQ-034 rst asserted in the second cycle of an EXEC for opcode 14 -> next cycle: IDLE, res_valid=0, alu_op=0, queue empty; the next command completes normally.
REQ-035 Four back-to-back commands (opcodes 0,12,14,5) with FIFO -> results returned in order with per-command latency per REQ-025.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: opcode codes, opcode->ASCII op-string table,
// FSM state encoding and the queued command record.
package alu_seq_pkg;

  localparam int OPC_W  = 4;
  localparam int DATA_W = 16;
  localparam int RES_W  = 32;
  localparam int OP_W   = 25;

  localparam logic [OPC_W-1:0] OPC_OR      = 4'd0;
  localparam logic [OPC_W-1:0] OPC_AND     = 4'd1;
  localparam logic [OPC_W-1:0] OPC_NOR     = 4'd2;
  localparam logic [OPC_W-1:0] OPC_XOR     = 4'd3;
  localparam logic [OPC_W-1:0] OPC_XNOR    = 4'd4;
  localparam logic [OPC_W-1:0] OPC_SHR     = 4'd5;
  localparam logic [OPC_W-1:0] OPC_SHL     = 4'd6;
  localparam logic [OPC_W-1:0] OPC_ASR     = 4'd7;
  localparam logic [OPC_W-1:0] OPC_ASL     = 4'd8;
  localparam logic [OPC_W-1:0] OPC_ROR     = 4'd9;
  localparam logic [OPC_W-1:0] OPC_ROL     = 4'd10;
  localparam logic [OPC_W-1:0] OPC_CMP     = 4'd11;
  localparam logic [OPC_W-1:0] OPC_ADD     = 4'd12;
  localparam logic [OPC_W-1:0] OPC_SUB     = 4'd13;
  localparam logic [OPC_W-1:0] OPC_MUL     = 4'd14;
  localparam logic [OPC_W-1:0] OPC_ILLEGAL = 4'd15;

  // ASCII bytes of each op string, zero-extended; entry 15 never reaches the ALU.
  localparam logic [OP_W-1:0] OP_ASCII [16] = '{
    25'h00007C,  // "|"
    25'h000026,  // "&"
    25'h007E7C,  // "~|"
    25'h00005E,  // "^"
    25'h007E5E,  // "~^"
    25'h003E3E,  // ">>"
    25'h003C3C,  // "<<"
    25'h617372,  // "asr"
    25'h61736C,  // "asl"
    25'h726F72,  // "ror"
    25'h726F6C,  // "rol"
    25'h636D70,  // "cmp"
    25'h00002B,  // "+"
    25'h00002D,  // "-"
    25'h00002A,  // "*"
    25'h000000
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  function automatic logic [OP_W-1:0] op_ascii(input logic [OPC_W-1:0] opcode);
    return OP_ASCII[opcode];
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Small synchronous command queue for alu_seq (used when ALU_SEQ_FIFO_EN is defined).
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      // simultaneous push and pop leaves the occupancy unchanged
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Command sequencer in front of an external ALU: one command in flight, result handshake.
// Optional command queue enabled with macro ALU_SEQ_FIFO_EN.
//
// state | meaning
// IDLE  | waiting for a command (queue head or direct input)
// EXEC  | operands/op string driven to the ALU, latency counter running
// DONE  | result held on res_data/res_err until res_ready
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MUL_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [RES_W-1:0]  alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_err
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] alu_a_nxt;
  logic [DATA_W-1:0] alu_b_nxt;
  logic [OP_W-1:0]   alu_op_nxt;
  logic [RES_W-1:0]  res_data_nxt;
  logic              res_err_nxt;

  cmd_t cmd;
  logic cmd_avail;
  logic take;

  assign take = (state == ST_IDLE) && cmd_avail;

`ifdef ALU_SEQ_FIFO_EN
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [$bits(cmd_t)-1:0]     fifo_head;
  logic                        unused_fifo_count;

  assign in_ready          = !rst && !fifo_full;
  assign cmd               = cmd_t'(fifo_head);
  assign cmd_avail         = !fifo_empty;
  assign unused_fifo_count = ^fifo_count;

  alu_seq_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid && in_ready),
    .push_data ({in_opcode, in_a, in_b}),
    .pop       (take),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
`else
  // Without a queue the command is taken straight off the input port.
  assign in_ready  = !rst && (state == ST_IDLE);
  assign cmd       = cmd_t'({in_opcode, in_a, in_b});
  assign cmd_avail = in_valid;
`endif

  assign res_valid = (state == ST_DONE);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    alu_a_nxt    = alu_a;
    alu_b_nxt    = alu_b;
    alu_op_nxt   = alu_op;
    res_data_nxt = res_data;
    res_err_nxt  = res_err;
    unique case (state)
      ST_IDLE: begin
        if (take) begin
          if (cmd.opcode == OPC_ILLEGAL) begin
            state_nxt    = ST_DONE;
            res_data_nxt = '0;
            res_err_nxt  = 1'b1;
          end else begin
            state_nxt   = ST_EXEC;
            alu_a_nxt   = cmd.a;
            alu_b_nxt   = cmd.b;
            alu_op_nxt  = op_ascii(cmd.opcode);
            res_err_nxt = 1'b0;
            // counter holds remaining EXEC cycles minus one
            cnt_nxt     = (cmd.opcode == OPC_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
          end
        end
      end
      ST_EXEC: begin
        if (cnt == '0) begin
          state_nxt    = ST_DONE;
          res_data_nxt = alu_out;
          alu_a_nxt    = '0;
          alu_b_nxt    = '0;
          alu_op_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      alu_a    <= alu_a_nxt;
      alu_b    <= alu_b_nxt;
      alu_op   <= alu_op_nxt;
      res_data <= res_data_nxt;
      res_err  <= res_err_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a stub ALU; covers both queue and direct builds.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [24:0] alu_op;
  logic [31:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;

  int total = 0;
  int bad   = 0;

`ifdef ALU_SEQ_FIFO_EN
  localparam int EXP_DRAIN = 5;
`else
  localparam int EXP_DRAIN = 1;
`endif

  alu_seq #(.FIFO_DEPTH(4), .MUL_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  // stub ALU keyed on the op string; unmodelled ops echo the string xor operands
  always_comb begin
    case (alu_op)
      25'h00002B: alu_out = {16'h0, alu_a} + {16'h0, alu_b};
      25'h00002A: alu_out = {16'h0, alu_a} * {16'h0, alu_b};
      25'h00007C: alu_out = {16'h0, alu_a | alu_b};
      25'h003E3E: alu_out = {16'h0, alu_a >> alu_b[3:0]};
      default:    alu_out = {7'h0, alu_op} ^ {alu_a, alu_b};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // issue one command from IDLE and follow it through to the handshake
  task automatic run_cmd(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [24:0] exp_op, input int lat,
                         input logic [31:0] exp_data, input logic exp_err);
    int guard = 0;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
`ifdef ALU_SEQ_FIFO_EN
    chk({tag, "_queued"}, 32'(alu_op), 32'h0);
    @(negedge clk);
`endif
    for (int i = 0; i < lat; i++) begin
      chk({tag, "_op"}, 32'(alu_op), 32'(exp_op));
      chk({tag, "_a"}, 32'(alu_a), 32'(a));
      chk({tag, "_b"}, 32'(alu_b), 32'(b));
      chk({tag, "_busy"}, 32'(res_valid), 32'h0);
      @(negedge clk);
    end
    chk({tag, "_vld"}, 32'(res_valid), 32'h1);
    chk({tag, "_data"}, res_data, exp_data);
    chk({tag, "_err"}, 32'(res_err), 32'(exp_err));
    chk({tag, "_opclr"}, 32'(alu_op), 32'h0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_ack"}, 32'(res_valid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [3:0]  b2b_op  [4] = '{4'd0, 4'd12, 4'd14, 4'd5};
  logic [15:0] b2b_a   [4] = '{16'h0F00, 16'h0001, 16'h0003, 16'h0100};
  logic [15:0] b2b_b   [4] = '{16'h00F0, 16'h0002, 16'h0004, 16'h0004};
  logic [31:0] b2b_exp [4] = '{32'h00000FF0, 32'h00000003, 32'h0000000C, 32'h00000010};

  initial begin
    int guard;
    int n_res;
    int first;
    logic [31:0] got [4];

    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = 4'd0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    res_ready = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_res_err", 32'(res_err), 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_in_ready_after", 32'(in_ready), 32'h1);

    run_cmd("add_carry", 4'd12, 16'hFFFF, 16'h0001, 25'h00002B, 1, 32'h00010000, 1'b0);
    run_cmd("mul", 4'd14, 16'h0100, 16'h0100, 25'h00002A, 2, 32'h00010000, 1'b0);
    run_cmd("or", 4'd0, 16'hF0F0, 16'h0F0F, 25'h00007C, 1, 32'h0000FFFF, 1'b0);
    run_cmd("shr", 4'd5, 16'h8000, 16'h0004, 25'h003E3E, 1, 32'h00000800, 1'b0);
    run_cmd("asr_str", 4'd7, 16'h0000, 16'h0000, 25'h617372, 1, 32'h00617372, 1'b0);
    run_cmd("illegal", 4'd15, 16'h1234, 16'h5678, 25'h0, 0, 32'h0, 1'b1);
    run_cmd("cmp_str", 4'd11, 16'h0001, 16'h0002, 25'h636D70, 1, 32'h00626D72, 1'b0);

    // result stall: res_ready low 5 cycles while more commands are offered
    in_valid  = 1'b1;
    in_opcode = 4'd12;
    in_a      = 16'h0002;
    in_b      = 16'h0003;
    @(negedge clk);
    in_opcode = 4'd0;
    in_a      = 16'h0001;
    in_b      = 16'h0002;
    guard = 0;
    while (!res_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", 32'(res_valid), 32'h1);
      chk("stall_data", res_data, 32'h00000005);
      chk("stall_err", 32'(res_err), 32'h0);
      @(negedge clk);
    end
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    n_res = 0;
    for (int i = 0; i < 30; i++) begin
      if (res_valid) n_res++;
      @(negedge clk);
    end
    res_ready = 1'b0;
    chk("stall_result_count", 32'(n_res), 32'(EXP_DRAIN));
    chk("stall_idle_ready", 32'(in_ready), 32'h1);

    // reset in the second EXEC cycle of a multiply
    in_valid  = 1'b1;
    in_opcode = 4'd14;
    in_a      = 16'h0100;
    in_b      = 16'h0100;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef ALU_SEQ_FIFO_EN
    @(negedge clk);
`endif
    chk("rst_exec1_op", 32'(alu_op), 32'h0000002A);
    @(negedge clk);
    chk("rst_exec2_op", 32'(alu_op), 32'h0000002A);
    rst = 1'b1;
    #1;
    chk("rst_exec_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_exec_valid", 32'(res_valid), 32'h0);
    chk("rst_exec_op", 32'(alu_op), 32'h0);
    chk("rst_exec_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    chk("rst_exec_discard", 32'(res_valid), 32'h0);
    run_cmd("post_rst", 4'd12, 16'h0005, 16'h0007, 25'h00002B, 1, 32'h0000000C, 1'b0);

`ifdef ALU_SEQ_FIFO_EN
    // four back-to-back commands through the queue
    res_ready = 1'b1;
    n_res = 0;
    first = -1;
    for (int c = 0; c < 40; c++) begin
      if (res_valid) begin
        if (n_res < 4) got[n_res] = res_data;
        if (first < 0) first = c;
        n_res++;
      end
      if (c < 4) begin
        chk("b2b_in_ready", 32'(in_ready), 32'h1);
        in_valid  = 1'b1;
        in_opcode = b2b_op[c];
        in_a      = b2b_a[c];
        in_b      = b2b_b[c];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    chk("b2b_count", 32'(n_res), 32'h4);
    chk("b2b_first_latency", 32'(first), 32'h3);
    for (int k = 0; k < 4; k++) chk("b2b_order", got[k], b2b_exp[k]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
